perceptron_trainer: RTL and testbench

Training stage of the perceptron branch predictor, sitting directly upstream of the weight table's write port. On each resolved branch it reads the indexed perceptron's weights, recomputes the dot product against the global-history snapshot taken at prediction time, and applies the perceptron learning rule. When training is required, it drives `update_enable` and `weight_update` back into the weight table. Processing is sequential, one multiply-accumulate per cycle, to keep area small.

---
 rtl/perceptron_trainer_if.sv | 43 ++++
 rtl/perceptron_trainer.sv | 182 ++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: groups the resolved-branch request handshake, the
// weight-table read/write port and the statistics counters of the
// perceptron trainer into one bundle.
//   master : side that issues resolved branches and owns the weight table
//            (drives res_*, tbl_weights; observes everything else)
//   slave  : the trainer itself (perceptron_trainer)
// Signals:
//   res_valid/res_ready      request handshake
//   res_index/res_taken/res_history  resolved branch payload
//   tbl_index                index for both the table read and the write
//   tbl_weights              weights read combinationally at tbl_index
//   update_enable            one-cycle write strobe
//   weight_update            new weight vector, qualified by update_enable
//   train_count/mispredict_count  saturating 16-bit statistics
interface perceptron_trainer_if #(
    parameter int N     = 62,
    parameter int WIDTH = 8,
    parameter int INDEX = 6
);
    logic                        res_valid;
    logic                        res_ready;
    logic [INDEX-1:0]            res_index;
    logic                        res_taken;
    logic [N-2:0]                res_history;
    logic [INDEX-1:0]            tbl_index;
    logic [N-1:0][WIDTH-1:0]     tbl_weights;
    logic                        update_enable;
    logic [N-1:0][WIDTH-1:0]     weight_update;
    logic [15:0]                 train_count;
    logic [15:0]                 mispredict_count;

    modport master (
        output res_valid, res_index, res_taken, res_history, tbl_weights,
        input  res_ready, tbl_index, update_enable, weight_update,
               train_count, mispredict_count
    );

    modport slave (
        input  res_valid, res_index, res_taken, res_history, tbl_weights,
        output res_ready, tbl_index, update_enable, weight_update,
               train_count, mispredict_count
    );
endinterface

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: training stage of a perceptron branch predictor.
// For each resolved branch it fetches the indexed perceptron's weights,
// recomputes the dot product against the prediction-time history one element
// per cycle (add/subtract only), and when the outcome was mispredicted or the
// output magnitude is within the threshold it writes back the weights nudged
// by t*x with saturation.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any in-flight request
//   bus    perceptron_trainer_if.slave (request, table port, counters)
// All outputs are driven straight from registers.
module perceptron_trainer #(
    parameter int N         = 62,
    parameter int WIDTH     = 8,
    parameter int INDEX     = 6,
    parameter int THRESHOLD = 131,
    parameter int SUMW      = WIDTH + $clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    perceptron_trainer_if.slave  bus
);
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0]          K_LAST  = KW'(N - 1);
    localparam logic [KW-1:0]          K_ONE   = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [15:0]            CNT_MAX = 16'hFFFF;
    localparam logic [15:0]            CNT_ONE = 16'h0001;
    localparam logic signed [SUMW-1:0] THR_POS = SUMW'(THRESHOLD);
    localparam logic signed [SUMW-1:0] THR_NEG = -THR_POS;
    localparam logic [WIDTH-1:0]       W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]       W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]       W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ACCUM  = 3'd2,
        DECIDE = 3'd3,
        WRITE  = 3'd4
    } state_t;

    state_t                  state_r;
    logic                    res_ready_r;
    logic [INDEX-1:0]        tbl_index_r;
    logic                    taken_r;
    logic [N-2:0]            history_r;
    logic [N-1:0][WIDTH-1:0] w_buf_r;
    logic signed [SUMW-1:0]  acc_r;
    logic [KW-1:0]           k_r;
    logic                    update_enable_r;
    logic [N-1:0][WIDTH-1:0] weight_update_r;
    logic [15:0]             train_count_r;
    logic [15:0]             mispredict_count_r;

    logic [N-1:0]            x_vec_s;
    logic [WIDTH-1:0]        w_sel_s;
    logic signed [SUMW-1:0]  w_ext_s;
    logic signed [SUMW-1:0]  acc_next_s;
    logic                    pred_s;
    logic                    mispredict_s;
    logic                    in_band_s;
    logic                    train_s;
    logic [N-1:0][WIDTH-1:0] new_weights_s;

    // Step a weight by +1 or -1, clamping at the signed WIDTH-bit limits.
    function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] w,
                                                  input logic up);
        logic [WIDTH-1:0] r;
        if (up) begin
            r = (w == W_MAX) ? w : w + W_ONE;
        end else begin
            r = (w == W_MIN) ? w : w - W_ONE;
        end
        return r;
    endfunction

    // Input vector as bits: bit k set means x_k = +1; bit 0 is the bias input.
    assign x_vec_s = {history_r, 1'b1};

    // One accumulate step: add or subtract the sign-extended weight k.
    always_comb begin
        w_sel_s = w_buf_r[k_r];
        w_ext_s = {{(SUMW-WIDTH){w_sel_s[WIDTH-1]}}, w_sel_s};
        if (x_vec_s[k_r]) begin
            acc_next_s = acc_r + w_ext_s;
        end else begin
            acc_next_s = acc_r - w_ext_s;
        end
    end

    // Training decision and the candidate updated weight vector.
    always_comb begin
        pred_s       = ~acc_r[SUMW-1];
        mispredict_s = pred_s ^ taken_r;
        in_band_s    = (acc_r <= THR_POS) && (acc_r >= THR_NEG);
        train_s      = mispredict_s | in_band_s;
        new_weights_s = '0;
        // t*x_k is +1 exactly when the outcome agrees with the input sign.
        for (int i = 0; i < N; i++) begin
            new_weights_s[i] = sat_step(w_buf_r[i], ~(taken_r ^ x_vec_s[i]));
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            res_ready_r        <= 1'b1;
            tbl_index_r        <= '0;
            taken_r            <= 1'b0;
            history_r          <= '0;
            w_buf_r            <= '0;
            acc_r              <= '0;
            k_r                <= '0;
            update_enable_r    <= 1'b0;
            weight_update_r    <= '0;
            train_count_r      <= '0;
            mispredict_count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // tbl_index changes only here so the read and the later
                    // write both address the same perceptron.
                    if (bus.res_valid && res_ready_r) begin
                        tbl_index_r <= bus.res_index;
                        taken_r     <= bus.res_taken;
                        history_r   <= bus.res_history;
                        res_ready_r <= 1'b0;
                        state_r     <= FETCH;
                    end
                end
                FETCH: begin
                    w_buf_r <= bus.tbl_weights;
                    acc_r   <= '0;
                    k_r     <= '0;
                    state_r <= ACCUM;
                end
                ACCUM: begin
                    acc_r <= acc_next_s;
                    if (k_r == K_LAST) begin
                        state_r <= DECIDE;
                    end else begin
                        k_r <= k_r + K_ONE;
                    end
                end
                DECIDE: begin
                    if (mispredict_s && (mispredict_count_r != CNT_MAX)) begin
                        mispredict_count_r <= mispredict_count_r + CNT_ONE;
                    end
                    if (train_s) begin
                        weight_update_r <= new_weights_s;
                        update_enable_r <= 1'b1;
                        state_r         <= WRITE;
                    end else begin
                        res_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                WRITE: begin
                    update_enable_r <= 1'b0;
                    if (train_count_r != CNT_MAX) begin
                        train_count_r <= train_count_r + CNT_ONE;
                    end
                    res_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    update_enable_r <= 1'b0;
                    res_ready_r     <= 1'b1;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    assign bus.res_ready        = res_ready_r;
    assign bus.tbl_index        = tbl_index_r;
    assign bus.update_enable    = update_enable_r;
    assign bus.weight_update    = weight_update_r;
    assign bus.train_count      = train_count_r;
    assign bus.mispredict_count = mispredict_count_r;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed, self-checking bench for perceptron_trainer.
// A weight-table memory answers reads and absorbs writes. A reference model
// computes, at each accept, the dot product, training decision and new
// weights with plain integer arithmetic, and derives the cycles at which the
// strobe, ready and counters must change; a compare process checks the DUT
// against that on every cycle. Literal expectations pin the model.
module tb_perceptron_trainer;
    localparam int N         = 62;
    localparam int WIDTH     = 8;
    localparam int INDEX     = 6;
    localparam int THRESHOLD = 131;
    localparam int WMAX      = (1 << (WIDTH - 1)) - 1;
    localparam int WMIN      = -(1 << (WIDTH - 1));

    typedef logic [N-1:0][WIDTH-1:0] wvec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    perceptron_trainer_if #(.N(N), .WIDTH(WIDTH), .INDEX(INDEX)) bus ();

    perceptron_trainer #(.N(N), .WIDTH(WIDTH), .INDEX(INDEX), .THRESHOLD(THRESHOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input wvec_t act, input wvec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Weight table: combinational read, write on the strobe or on a bench load.
    wvec_t            tbl_mem [0:(1<<INDEX)-1];
    logic             load_req = 1'b0;
    logic [INDEX-1:0] load_idx = '0;
    wvec_t            load_vec = '0;

    assign bus.tbl_weights = tbl_mem[bus.tbl_index];

    always @(posedge clk) begin
        if (bus.update_enable) tbl_mem[bus.tbl_index] = bus.weight_update;
        else if (load_req) tbl_mem[load_idx] = load_vec;
    end

    // Reference perceptron rule in integer arithmetic.
    function automatic void model(input wvec_t w, input logic tk, input logic [N-2:0] h,
                                  output int acc, output bit mis, output bit trn,
                                  output wvec_t nw);
        int x, t, v;
        t   = tk ? 1 : -1;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            x = (k == 0) ? 1 : (h[k-1] ? 1 : -1);
            acc += x * int'($signed(w[k]));
        end
        mis = ((acc >= 0) != tk);
        trn = mis || ((acc <= THRESHOLD) && (acc >= -THRESHOLD));
        for (int k = 0; k < N; k++) begin
            x = (k == 0) ? 1 : (h[k-1] ? 1 : -1);
            v = int'($signed(w[k])) + t * x;
            if (v > WMAX) v = WMAX;
            if (v < WMIN) v = WMIN;
            nw[k] = WIDTH'(v);
        end
    endfunction

    // Model timeline and observations.
    int               ready_cyc = 0, strobe_cyc = -1, mis_cyc = -1, train_cyc = -1;
    int               acc_cyc = 0, acc_gap = 0, strobe_off = 0, ready_off = 0;
    int               n_strobes = 0, exp_mis = 0, exp_train = 0, m_acc = 0;
    bit               m_mis, m_trn, prev_ready = 1'b1;
    logic [INDEX-1:0] exp_idx = '0;
    wvec_t            exp_wu = '0, last_wu = '0;

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", bus.res_ready, 1'b1);
            chk("rst_upd_en", bus.update_enable, 1'b0);
            chk("rst_tbl_index", bus.tbl_index, '0);
            chk("rst_train_cnt", bus.train_count, 16'd0);
            chk("rst_mis_cnt", bus.mispredict_count, 16'd0);
            chk_vec("rst_weight_update", bus.weight_update, '0);
            exp_mis = 0; exp_train = 0; ready_cyc = 0;
            strobe_cyc = -1; mis_cyc = -1; train_cyc = -1; prev_ready = 1'b1;
        end else begin
            if (cyc == mis_cyc) exp_mis++;
            if (cyc == train_cyc) exp_train++;
            chk("res_ready", bus.res_ready, (cyc >= ready_cyc));
            chk("update_enable", bus.update_enable, (cyc == strobe_cyc));
            if (cyc == strobe_cyc) begin
                chk("strobe_tbl_index", bus.tbl_index, exp_idx);
                chk_vec("weight_update", bus.weight_update, exp_wu);
                last_wu    = bus.weight_update;
                strobe_off = cyc - acc_cyc;
            end
            if (bus.update_enable) n_strobes++;
            chk("train_count", bus.train_count, exp_train);
            chk("mispredict_count", bus.mispredict_count, exp_mis);
            if (bus.res_ready && !prev_ready) ready_off = cyc - acc_cyc;
            prev_ready = bus.res_ready;
            if (bus.res_valid && bus.res_ready) begin
                acc_gap = cyc - acc_cyc;
                acc_cyc = cyc;
                exp_idx = bus.res_index;
                model(tbl_mem[bus.res_index], bus.res_taken, bus.res_history,
                      m_acc, m_mis, m_trn, exp_wu);
                ready_cyc  = cyc + (m_trn ? N + 4 : N + 3);
                strobe_cyc = m_trn ? cyc + N + 3 : -1;
                mis_cyc    = m_mis ? cyc + N + 3 : -1;
                train_cyc  = m_trn ? cyc + N + 4 : -1;
            end
        end
    end

    task automatic load(input logic [INDEX-1:0] idx, input wvec_t v);
        load_idx = idx;
        load_vec = v;
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Hold a request until accepted (bounded), then drop valid.
    task automatic send(input logic [INDEX-1:0] idx, input logic tk, input logic [N-2:0] h);
        int waitc;
        bus.res_valid   = 1'b1;
        bus.res_index   = idx;
        bus.res_taken   = tk;
        bus.res_history = h;
        waitc = 0;
        @(negedge clk);
        while (!bus.res_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_within_budget", bus.res_ready, 1'b1);
        @(posedge clk);
        #1 bus.res_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (70) @(posedge clk);
        #1;
    endtask

    wvec_t            v;
    logic [N-2:0]     h1;
    int               strobes_before;

    initial begin
        bus.res_valid   = 1'b0;
        bus.res_index   = '0;
        bus.res_taken   = 1'b0;
        bus.res_history = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero weights, taken, history all ones.
        load(6'd5, '0);
        send(6'd5, 1'b1, '1);
        settle();
        chk("zero_model_acc", m_acc, 0);
        chk("zero_strobe_offset", strobe_off, 65);
        chk("zero_w0", last_wu[0], 8'h01);
        chk("zero_w61", last_wu[61], 8'h01);
        chk("zero_tbl_written", tbl_mem[5][30], 8'h01);
        chk("zero_train_cnt", bus.train_count, 16'd1);
        chk("zero_mis_cnt", bus.mispredict_count, 16'd0);

        // Positive saturation.
        for (int k = 0; k < N; k++) v[k] = 8'd127;
        load(6'd7, v);
        send(6'd7, 1'b1, '0);
        settle();
        chk("pos_model_acc", m_acc, -7620);
        chk("pos_w0", last_wu[0], 8'h7F);
        chk("pos_w1", last_wu[1], 8'h7E);
        chk("pos_train_cnt", bus.train_count, 16'd2);
        chk("pos_mis_cnt", bus.mispredict_count, 16'd1);

        // Negative saturation.
        for (int k = 0; k < N; k++) v[k] = 8'h80;
        load(6'd8, v);
        send(6'd8, 1'b0, '0);
        settle();
        chk("neg_model_acc", m_acc, 7680);
        chk("neg_w0", last_wu[0], 8'h80);
        chk("neg_w61", last_wu[61], 8'h81);
        chk("neg_mis_cnt", bus.mispredict_count, 16'd2);

        // Threshold boundary: acc = 131 trains, acc = 132 does not.
        h1 = '0;
        h1[0] = 1'b1;
        v = '0;
        v[0] = 8'd127;
        v[1] = 8'd4;
        load(6'd9, v);
        send(6'd9, 1'b1, h1);
        settle();
        chk("thr131_model_acc", m_acc, 131);
        chk("thr131_w0", last_wu[0], 8'h7F);
        chk("thr131_w1", last_wu[1], 8'h05);
        chk("thr131_w2", last_wu[2], 8'hFF);
        chk("thr131_train_cnt", bus.train_count, 16'd4);
        v[1] = 8'd5;
        load(6'd9, v);
        strobes_before = n_strobes;
        send(6'd9, 1'b1, h1);
        settle();
        chk("thr132_model_acc", m_acc, 132);
        chk("thr132_no_strobe", n_strobes, strobes_before);
        chk("thr132_ready_offset", ready_off, 65);
        chk("thr132_train_cnt", bus.train_count, 16'd4);

        // Back-to-back with valid held high.
        load(6'd10, '0);
        load(6'd11, '0);
        send(6'd10, 1'b1, '1);
        send(6'd11, 1'b1, '0);
        chk("b2b_accept_gap", acc_gap, 66);
        settle();
        chk("b2b_train_cnt", bus.train_count, 16'd6);

        // Reset in the middle of ACCUM.
        load(6'd12, '0);
        strobes_before = n_strobes;
        send(6'd12, 1'b0, '1);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("rstmid_no_strobe", n_strobes, strobes_before);
        chk("rstmid_train_cnt", bus.train_count, 16'd0);
        chk("rstmid_mis_cnt", bus.mispredict_count, 16'd0);
        chk("rstmid_ready", bus.res_ready, 1'b1);
        @(posedge clk);
        #1;
        send(6'd12, 1'b1, '1);
        settle();
        chk("rstmid_fresh_train_cnt", bus.train_count, 16'd1);
        chk("rstmid_fresh_w0", last_wu[0], 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
